// File: rtl/ship_controller_pkg.sv
// Shared screen geometry and ship FSM state type for the space game blocks.
package space_pkg;
    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int SCREEN_CORDW = 16;
    localparam int SHIP_W_PIX   = 68;
    localparam int SHIP_Y       = 300;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_CALC = 2'd1,
        ST_MOVE = 2'd2
    } ship_state_t;
endpackage

// File: rtl/ship_controller_if.sv
// Ship controller bus: frame/tilt/button inputs and ship position/fire outputs.
interface ship_if #(
    parameter int CORDW = space_pkg::SCREEN_CORDW
);
    // frame and accel_valid are one-cycle strobes with no ready; the controller
    // always accepts them (a frame outside WAIT is dropped by design).
    logic                    frame;
    logic                    accel_valid;
    logic signed [15:0]      accel_x;
    logic                    fire_n;
    logic        [CORDW-1:0] ship_x;
    logic        [CORDW-1:0] ship_y;
    logic                    fire;
    logic                    stale;

    modport master (
        output frame, accel_valid, accel_x, fire_n,
        input  ship_x, ship_y, fire, stale
    );

    modport slave (
        input  frame, accel_valid, accel_x, fire_n,
        output ship_x, ship_y, fire, stale
    );
endinterface

// File: rtl/ship_controller_debounce.sv
// Two-flop synchronizer plus level debouncer for active-low push buttons.
module debounce #(
    parameter int STABLE_CYC = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(STABLE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // A new level is taken only once it has differed from the current one
    // for STABLE_CYC consecutive synchronized samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(STABLE_CYC - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ship_controller.sv
// Tilt-driven ship position controller with debounced, rate-limited fire button.
module ship_controller
    import space_pkg::*;
#(
    parameter int H_RES         = space_pkg::H_RES,
    parameter int SCREEN_CORDW  = space_pkg::SCREEN_CORDW,
    parameter int SHIP_W_PIX    = space_pkg::SHIP_W_PIX,
    parameter int SHIP_Y        = space_pkg::SHIP_Y,
    parameter int DEAD_ZONE     = 16,
    parameter int SPEED_SHIFT   = 5,
    parameter int MAX_STEP      = 8,
    parameter int STALE_FRAMES  = 8,
    parameter int DEBOUNCE_CYC  = 250000,
    parameter int FIRE_COOLDOWN = 30
) (
    input  logic        clk_pix,
    input  logic        rst_n,
    ship_if.slave       bus,
    output ship_state_t state
);
    localparam int X_MAX = H_RES - SHIP_W_PIX;
    localparam int SW    = SCREEN_CORDW + 2;
    localparam int SCW   = $clog2(STALE_FRAMES + 1);
    localparam int CDW   = $clog2(FIRE_COOLDOWN + 1);

    ship_state_t              state_q, state_d;
    logic signed [15:0]       sample_q, tilt_q, step_q, step_d, shifted;
    logic signed [16:0]       tilt_ext, tilt_abs;
    logic        [SCW-1:0]    stale_cnt_q;
    logic                     stale_now;
    logic        [SCREEN_CORDW-1:0] x_q, x_d;
    logic signed [SW-1:0]     sum;
    logic        [CDW-1:0]    cooldown_q;
    logic                     btn_level, btn_level_d, press, fire_q;

    assign stale_now = (stale_cnt_q == SCW'(STALE_FRAMES));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if (bus.frame) state_d = ST_CALC;
            ST_CALC: state_d = ST_MOVE;
            ST_MOVE: state_d = ST_WAIT;
            default: state_d = ST_WAIT;
        endcase
    end

    // Tilt to per-frame step: dead zone, arithmetic scale, symmetric saturation.
    always_comb begin
        tilt_ext = {tilt_q[15], tilt_q};
        tilt_abs = tilt_ext[16] ? -tilt_ext : tilt_ext;
        shifted  = tilt_q >>> SPEED_SHIFT;
        step_d   = shifted;
        if (tilt_abs < 17'(DEAD_ZONE))        step_d = '0;
        else if (shifted > 16'(MAX_STEP))     step_d = 16'(MAX_STEP);
        else if (shifted < -16'(MAX_STEP))    step_d = -16'(MAX_STEP);
    end

    // Widened signed sum so a left move from column 0 cannot wrap.
    always_comb begin
        sum = $signed({2'b00, x_q}) + SW'(step_q);
        x_d = sum[SCREEN_CORDW-1:0];
        if (sum[SW-1])                x_d = '0;
        else if (sum > SW'(X_MAX))    x_d = SCREEN_CORDW'(X_MAX);
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT;
            sample_q    <= '0;
            stale_cnt_q <= SCW'(STALE_FRAMES);
            tilt_q      <= '0;
            step_q      <= '0;
            x_q         <= SCREEN_CORDW'(X_MAX / 2);
        end else begin
            state_q <= state_d;
            if (bus.accel_valid) begin
                sample_q    <= bus.accel_x;
                stale_cnt_q <= '0;
            end else if (bus.frame && !stale_now) begin
                stale_cnt_q <= stale_cnt_q + 1'b1;
            end
            // Snapshot at the frame edge so a coincident sample waits a frame.
            if (state_q == ST_WAIT && bus.frame) tilt_q <= stale_now ? '0 : sample_q;
            if (state_q == ST_CALC) step_q <= step_d;
            if (state_q == ST_MOVE) x_q <= x_d;
        end
    end

    debounce #(
        .STABLE_CYC(DEBOUNCE_CYC)
    ) u_fire_db (
        .clk  (clk_pix),
        .rst_n(rst_n),
        .raw  (bus.fire_n),
        .level(btn_level)
    );

    assign press = btn_level_d & ~btn_level;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            btn_level_d <= 1'b1;
            fire_q      <= 1'b0;
            cooldown_q  <= '0;
        end else begin
            btn_level_d <= btn_level;
            fire_q      <= press && (cooldown_q == '0);
            if (press && (cooldown_q == '0))
                cooldown_q <= CDW'(FIRE_COOLDOWN);
            else if (bus.frame && (cooldown_q != '0))
                cooldown_q <= cooldown_q - 1'b1;
        end
    end

    assign bus.ship_x = x_q;
    assign bus.ship_y = SCREEN_CORDW'(SHIP_Y);
    assign bus.fire   = fire_q;
    assign bus.stale  = stale_now;
    assign state      = state_q;
endmodule

// File: doc/ship_controller.md
SHIP_CONTROLLER -- requirements
Module: ship_controller

Interface
REQ-001 Parameter H_RES, default 640, visible screen width in pixels.
REQ-002 Parameter SCREEN_CORDW, default 16, screen coordinate width in bits.
REQ-003 Parameter SHIP_W_PIX, default 68, drawn ship width in pixels (17 x scale 4).
REQ-004 Parameter SHIP_Y, default 300, fixed ship row.
REQ-005 Parameter DEAD_ZONE, default 16, minimum tilt magnitude that moves the ship.
REQ-006 Parameter SPEED_SHIFT, default 5, right-shift applied to tilt to get step.
REQ-007 Parameter MAX_STEP, default 8, step saturation in pixels per frame.
REQ-008 Parameter STALE_FRAMES, default 8, frames without a sample before tilt is forced to 0.
REQ-009 Parameter DEBOUNCE_CYC, default 250000, stable cycles (10 ms at 25 MHz) to accept a button level.
REQ-010 Parameter FIRE_COOLDOWN, default 30, minimum frames between fire pulses.
REQ-011 clk_pix  in  1  pixel clock, single clock domain.
REQ-012 rst_n  in  1  asynchronous, active-low reset.
REQ-013 frame  in  1  one-cycle pulse at the start of each frame.
REQ-014 accel_valid  in  1  one-cycle strobe qualifying accel_x.
REQ-015 accel_x  in  16  signed tilt sample; positive means move right.
REQ-016 fire_n  in  1  raw push button, active-low, asynchronous to clk_pix.
REQ-017 ship_x  out  SCREEN_CORDW  ship left-edge column.
REQ-018 ship_y  out  SCREEN_CORDW  ship top row, constant SHIP_Y.
REQ-019 fire  out  1  one-cycle shot request.
REQ-020 stale  out  1  high while the tilt sample is stale.

Function
REQ-021 Every accel_valid SHALL latch accel_x into the sample register and clear the stale frame counter.
REQ-022 Each frame without an accel_valid since the previous frame SHALL increment the stale counter, which saturates at STALE_FRAMES; stale SHALL be high when the counter equals STALE_FRAMES, and the effective tilt SHALL then be 0.
REQ-023 The FSM SHALL have three states, entered in order: WAIT (on frame) -> CALC -> MOVE -> WAIT.
REQ-024 CALC SHALL compute step = 0 if |tilt| < DEAD_ZONE; otherwise step = tilt >>> SPEED_SHIFT (arithmetic shift), saturated to ±MAX_STEP.
REQ-025 MOVE SHALL compute ship_x + step in at least SCREEN_CORDW+2 signed bits and clamp the result to [0, X_MAX], where X_MAX = H_RES - SHIP_W_PIX (572); wrap-around is forbidden.
REQ-026 ship_x SHALL update exactly 2 cycles after the frame pulse and hold at all other times.
REQ-027 If accel_valid and frame coincide, the previously latched sample SHALL be used for this frame and the new sample SHALL be used for the next.
REQ-028 A frame pulse arriving outside WAIT SHALL be ignored.
REQ-029 fire_n SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYC consecutive equal samples.
REQ-030 A debounced press edge (1->0) with cooldown = 0 SHALL assert fire for one cycle, 1 cycle after the debounced edge, and load cooldown = FIRE_COOLDOWN.
REQ-031 A press while cooldown != 0 SHALL be dropped, not queued; a held button SHALL yield exactly one pulse.
REQ-032 The cooldown counter SHALL decrement by 1 on each frame, saturating at 0.

Reset
REQ-033 On reset: ship_x = X_MAX/2 (286); ship_y = SHIP_Y; fire = 0; stale = 1; sample = 0; stale counter = STALE_FRAMES; cooldown = 0; FSM = WAIT; synchronizer and debounced level = 1 (released).
REQ-034 Reset asserted mid-calculation SHALL abort the calculation with no partial ship_x update.

Structure
REQ-035 H_RES, V_RES, SCREEN_CORDW, SHIP_W_PIX, SHIP_Y and the FSM state enum SHALL live in the shared package space_pkg.
REQ-036 The synchronizer and debouncer SHALL be one sub-module, debounce, reusable for KEY inputs.

Verification
REQ-037 After reset, with no accel_valid, apply 3 frames -> ship_x = 286 and stale = 1 throughout.
REQ-038 accel_x = +100, then 1 frame -> ship_x = 289 at frame+2; accel_x = -10, then 1 frame -> ship_x unchanged (dead zone).
REQ-039 accel_x = +1000 (step saturates to 8) from ship_x = 570, then 1 frame -> 572; repeat from ship_x = 4 with accel_x = -1000 -> 0; no wrap-around in either case.
REQ-040 One accel_valid, then 9 frames with no sample -> movement stops and stale = 1 from the 8th frame on; a new accel_valid clears stale immediately.
REQ-041 fire_n low for 20 ms with 2 ms bounce at the start -> exactly one fire pulse; a second press 10 frames later -> no pulse; a press at 31 frames -> one pulse.
REQ-042 rst_n asserted during CALC -> ship_x = 286 and FSM = WAIT immediately, with no fire output.
